// File: rtl/tetron_rotator.sv
// Tetromino rotation engine: owns piece/rotation state and runs a multi-cycle
// candidate/check/commit transaction. Optional wall kicks under TETRON_WALL_KICK_EN.
module tetron_rotator #(
    parameter int OFS_W   = 5,
    parameter int N_KICKS = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [2:0]           piece_type_i,
    input  logic                 spawn_i,
    input  logic                 rot_req_i,
    input  logic                 rot_dir_i,
    output logic                 rot_busy_o,
    output logic                 cand_valid_o,
    output logic [4*OFS_W-1:0]   cand_voffset_o,
    output logic [4*OFS_W-1:0]   cand_hoffset_o,
    output logic [OFS_W-1:0]     cand_hshift_o,
    input  logic                 chk_done_i,
    input  logic                 chk_collide_i,
    output logic [4*OFS_W-1:0]   cur_voffset_o,
    output logic [4*OFS_W-1:0]   cur_hoffset_o,
    output logic [1:0]           cur_rotation_o,
    output logic [2:0]           cur_piece_o,
    output logic                 rot_done_o,
    output logic                 rot_ok_o,
    output logic [OFS_W-1:0]     kick_hshift_o
);

`ifdef TETRON_WALL_KICK_EN
    localparam int MAX_K = N_KICKS;
`else
    localparam int MAX_K = 1;
`endif
    localparam logic [2:0] LAST_K = 3'(MAX_K - 1);

    localparam logic [2:0] Z0 = 3'b000;
    localparam logic [2:0] P1 = 3'b001;
    localparam logic [2:0] P2 = 3'b010;
    localparam logic [2:0] N1 = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CALC   = 3'd1,
        S_WAIT   = 3'd2,
        S_COMMIT = 3'd3,
        S_REJECT = 3'd4
    } state_t;

    typedef logic [3:0][OFS_W-1:0] ofs4_t;

    // Rotation-0 vertical offsets, packed {blk4,blk3,blk2,blk1} as 3-bit signed.
    function automatic logic [11:0] shape_v(input logic [2:0] p);
        case (p)
            3'd0:    shape_v = {Z0, Z0, Z0, Z0};
            3'd1:    shape_v = {P1, P1, Z0, Z0};
            3'd2:    shape_v = {N1, Z0, Z0, Z0};
            3'd3:    shape_v = {N1, N1, Z0, Z0};
            3'd4:    shape_v = {N1, N1, Z0, Z0};
            3'd5:    shape_v = {N1, Z0, Z0, Z0};
            3'd6:    shape_v = {N1, Z0, Z0, Z0};
            default: shape_v = {Z0, Z0, Z0, Z0};
        endcase
    endfunction

    function automatic logic [11:0] shape_h(input logic [2:0] p);
        case (p)
            3'd0:    shape_h = {P2, P1, Z0, N1};
            3'd1:    shape_h = {P1, Z0, P1, Z0};
            3'd2:    shape_h = {Z0, P1, N1, Z0};
            3'd3:    shape_h = {P1, Z0, N1, Z0};
            3'd4:    shape_h = {N1, Z0, P1, Z0};
            3'd5:    shape_h = {N1, P1, N1, Z0};
            3'd6:    shape_h = {P1, P1, N1, Z0};
            default: shape_h = {Z0, Z0, Z0, Z0};
        endcase
    endfunction

    function automatic ofs4_t expand(input logic [11:0] s);
        for (int b = 0; b < 4; b++) begin
            expand[b] = OFS_W'($signed(s[3*b +: 3]));
        end
    endfunction

    // Trial order 0, -1, +1, -2, +2; constant 0 when kicks are compiled out.
    function automatic logic [OFS_W-1:0] kick_shift(input logic [2:0] k);
`ifdef TETRON_WALL_KICK_EN
        case (k)
            3'd0:    kick_shift = {OFS_W{1'b0}};
            3'd1:    kick_shift = {OFS_W{1'b1}};
            3'd2:    kick_shift = OFS_W'(1);
            3'd3:    kick_shift = {{(OFS_W-1){1'b1}}, 1'b0};
            3'd4:    kick_shift = OFS_W'(2);
            default: kick_shift = {OFS_W{1'b0}};
        endcase
`else
        kick_shift = {OFS_W{1'b0}} & {OFS_W{k[0] & 1'b0}};
`endif
    endfunction

    state_t             state_q;
    logic [2:0]         k_q;
    logic               dir_q;
    logic               busy_q;
    logic               cand_valid_q;
    logic               rot_done_q;
    logic               rot_ok_q;
    ofs4_t              cand_v_q;
    ofs4_t              cand_h_q;
    logic [OFS_W-1:0]   cand_hs_q;
    ofs4_t              cur_v_q;
    ofs4_t              cur_h_q;
    logic [1:0]         cur_rot_q;
    logic [2:0]         cur_piece_q;
    logic [OFS_W-1:0]   kick_q;
    ofs4_t              cand_v_d;
    ofs4_t              cand_h_d;

    // Rotated candidate from the committed offsets; O keeps its shape.
    always_comb begin
        cand_v_d = cur_v_q;
        cand_h_d = cur_h_q;
        for (int b = 0; b < 4; b++) begin
            if (cur_piece_q == 3'd1) begin
                cand_v_d[b] = cur_v_q[b];
                cand_h_d[b] = cur_h_q[b];
            end else if (dir_q == 1'b0) begin
                cand_v_d[b] = cur_h_q[b];
                cand_h_d[b] = -cur_v_q[b];
            end else begin
                cand_v_d[b] = -cur_h_q[b];
                cand_h_d[b] = cur_v_q[b];
            end
        end
    end

    // Transaction FSM with all outputs registered; spawn aborts from any state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            k_q          <= 3'd0;
            dir_q        <= 1'b0;
            busy_q       <= 1'b0;
            cand_valid_q <= 1'b0;
            rot_done_q   <= 1'b0;
            rot_ok_q     <= 1'b0;
            cand_v_q     <= '0;
            cand_h_q     <= '0;
            cand_hs_q    <= '0;
            cur_v_q      <= '0;
            cur_h_q      <= '0;
            cur_rot_q    <= 2'd0;
            cur_piece_q  <= 3'd7;
            kick_q       <= '0;
        end else if (spawn_i) begin
            state_q      <= S_IDLE;
            k_q          <= 3'd0;
            busy_q       <= 1'b0;
            cand_valid_q <= 1'b0;
            rot_done_q   <= 1'b0;
            rot_ok_q     <= 1'b0;
            cur_piece_q  <= piece_type_i;
            cur_v_q      <= expand(shape_v(piece_type_i));
            cur_h_q      <= expand(shape_h(piece_type_i));
            cur_rot_q    <= 2'd0;
            kick_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    rot_done_q <= 1'b0;
                    rot_ok_q   <= 1'b0;
                    if (rot_req_i) begin
                        dir_q  <= rot_dir_i;
                        k_q    <= 3'd0;
                        busy_q <= 1'b1;
                        if (cur_piece_q == 3'd7) begin
                            rot_done_q <= 1'b1;
                            state_q    <= S_REJECT;
                        end else begin
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    cand_v_q     <= cand_v_d;
                    cand_h_q     <= cand_h_d;
                    cand_hs_q    <= kick_shift(k_q);
                    cand_valid_q <= 1'b1;
                    state_q      <= S_WAIT;
                end
                S_WAIT: begin
                    if (chk_done_i) begin
                        cand_valid_q <= 1'b0;
                        if (!chk_collide_i) begin
                            cur_v_q    <= cand_v_q;
                            cur_h_q    <= cand_h_q;
                            cur_rot_q  <= dir_q ? (cur_rot_q - 2'd1) : (cur_rot_q + 2'd1);
                            kick_q     <= cand_hs_q;
                            rot_done_q <= 1'b1;
                            rot_ok_q   <= 1'b1;
                            state_q    <= S_COMMIT;
                        end else if (k_q != LAST_K) begin
                            k_q     <= k_q + 3'd1;
                            state_q <= S_CALC;
                        end else begin
                            rot_done_q <= 1'b1;
                            rot_ok_q   <= 1'b0;
                            state_q    <= S_REJECT;
                        end
                    end
                end
                S_COMMIT, S_REJECT: begin
                    rot_done_q <= 1'b0;
                    rot_ok_q   <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: begin
                    busy_q       <= 1'b0;
                    cand_valid_q <= 1'b0;
                    rot_done_q   <= 1'b0;
                    rot_ok_q     <= 1'b0;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

    assign rot_busy_o     = busy_q;
    assign cand_valid_o   = cand_valid_q;
    assign cand_voffset_o = cand_v_q;
    assign cand_hoffset_o = cand_h_q;
    assign cand_hshift_o  = cand_hs_q;
    assign cur_voffset_o  = cur_v_q;
    assign cur_hoffset_o  = cur_h_q;
    assign cur_rotation_o = cur_rot_q;
    assign cur_piece_o    = cur_piece_q;
    assign rot_done_o     = rot_done_q;
    assign rot_ok_o       = rot_ok_q;
    assign kick_hshift_o  = kick_q;

endmodule
